ex_mem_stage: RTL and testbench

- Execute stage plus EX/MEM pipeline register of the 64-bit RV64I five-stage pipeline.
- Consumes the ID/EX register outputs.
- Performs ALU-control decode, operand forwarding, the ALU operation, branch compare and target computation.
- Registers the results for the MEM stage. Its registered branch-taken pulse drives the upstream IF/ID and ID/EX Flush inputs.

---
 rtl/ex_mem_stage.sv | 165 ++++++++++++++++
 tb/tb_ex_mem_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// RV64I execute stage: forwarding, ALU, branch resolution, and the EX/MEM pipeline register.
// A taken branch pulses for one cycle and squashes the wrong-path instruction that follows it.
module ex_mem_stage #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  Flush,
    input  logic [XLEN-1:0]       program_counter_addr,
    input  logic [XLEN-1:0]       read_data1,
    input  logic [XLEN-1:0]       read_data2,
    input  logic [XLEN-1:0]       immediate_value,
    input  logic [3:0]            function_code,
    input  logic [REG_ADDR_W-1:0] destination_reg,
    input  logic [REG_ADDR_W-1:0] source_reg1,
    input  logic [REG_ADDR_W-1:0] source_reg2,
    input  logic                  MemtoReg,
    input  logic                  RegWrite,
    input  logic                  Branch,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic                  ALUSrc,
    input  logic [1:0]            ALU_op,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    output logic [XLEN-1:0]       alu_result_out,
    output logic [XLEN-1:0]       write_data_out,
    output logic [REG_ADDR_W-1:0] destination_reg_out,
    output logic                  MemtoReg_out,
    output logic                  RegWrite_out,
    output logic                  MemWrite_out,
    output logic                  MemRead_out,
    output logic                  branch_taken_out,
    output logic [XLEN-1:0]       branch_target_out
);

    localparam int SHW = $clog2(XLEN);

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alu_ctl_e;

    alu_ctl_e        alu_ctl;
    logic [3:0]      alu_code;
    logic [XLEN-1:0] fwd_a, fwd_b, alu_b, alu_res, branch_target;
    logic [SHW-1:0]  shamt;
    logic            a_lt_s, a_lt_u, a_eq, branch_cond, branch_taken;

    // MEM stage result has priority over WB; x0 is never forwarded.
    always_comb begin
        fwd_a = read_data1;
        if (RegWrite_out && destination_reg_out != '0 && destination_reg_out == source_reg1)
            fwd_a = alu_result_out;
        else if (wb_reg_write && wb_rd != '0 && wb_rd == source_reg1)
            fwd_a = wb_data;
    end

    always_comb begin
        fwd_b = read_data2;
        if (RegWrite_out && destination_reg_out != '0 && destination_reg_out == source_reg2)
            fwd_b = alu_result_out;
        else if (wb_reg_write && wb_rd != '0 && wb_rd == source_reg2)
            fwd_b = wb_data;
    end

    assign alu_b = ALUSrc ? immediate_value : fwd_b;

    // I-type keeps funct7[5] only for srai, so addi never decodes as sub.
    always_comb begin
        alu_code = function_code;
        if (ALU_op == 2'b11 && function_code[2:0] != 3'b101)
            alu_code = {1'b0, function_code[2:0]};
        alu_ctl = ALU_ADD;
        case (ALU_op)
            2'b00: alu_ctl = ALU_ADD;
            2'b01: alu_ctl = ALU_SUB;
            default: begin
                case (alu_code)
                    4'b0000: alu_ctl = ALU_ADD;
                    4'b1000: alu_ctl = ALU_SUB;
                    4'b0111: alu_ctl = ALU_AND;
                    4'b0110: alu_ctl = ALU_OR;
                    4'b0100: alu_ctl = ALU_XOR;
                    4'b0001: alu_ctl = ALU_SLL;
                    4'b0101: alu_ctl = ALU_SRL;
                    4'b1101: alu_ctl = ALU_SRA;
                    4'b0010: alu_ctl = ALU_SLT;
                    4'b0011: alu_ctl = ALU_SLTU;
                    default: alu_ctl = ALU_ADD;
                endcase
            end
        endcase
    end

    assign shamt = alu_b[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (alu_ctl)
            ALU_ADD:  alu_res = fwd_a + alu_b;
            ALU_SUB:  alu_res = fwd_a - alu_b;
            ALU_AND:  alu_res = fwd_a & alu_b;
            ALU_OR:   alu_res = fwd_a | alu_b;
            ALU_XOR:  alu_res = fwd_a ^ alu_b;
            ALU_SLL:  alu_res = fwd_a << shamt;
            ALU_SRL:  alu_res = fwd_a >> shamt;
            ALU_SRA:  alu_res = $signed(fwd_a) >>> shamt;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(alu_b)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, fwd_a < alu_b};
            default:  alu_res = '0;
        endcase
    end

    assign a_eq   = (fwd_a == fwd_b);
    assign a_lt_s = ($signed(fwd_a) < $signed(fwd_b));
    assign a_lt_u = (fwd_a < fwd_b);

    always_comb begin
        branch_cond = 1'b0;
        case (function_code[2:0])
            3'b000:  branch_cond = a_eq;
            3'b001:  branch_cond = !a_eq;
            3'b100:  branch_cond = a_lt_s;
            3'b101:  branch_cond = !a_lt_s;
            3'b110:  branch_cond = a_lt_u;
            3'b111:  branch_cond = !a_lt_u;
            default: branch_cond = 1'b0;
        endcase
    end

    assign branch_taken  = Branch && branch_cond;
    assign branch_target = program_counter_addr + immediate_value;

    // The instruction behind a taken branch is captured as a bubble, same as Flush.
    always_ff @(posedge clk) begin
        if (reset || Flush || branch_taken_out) begin
            alu_result_out      <= '0;
            write_data_out      <= '0;
            destination_reg_out <= '0;
            MemtoReg_out        <= 1'b0;
            RegWrite_out        <= 1'b0;
            MemWrite_out        <= 1'b0;
            MemRead_out         <= 1'b0;
            branch_taken_out    <= 1'b0;
            branch_target_out   <= '0;
        end else if (stall) begin
            branch_taken_out    <= 1'b0;
        end else begin
            alu_result_out      <= alu_res;
            write_data_out      <= fwd_b;
            destination_reg_out <= destination_reg;
            MemtoReg_out        <= MemtoReg;
            RegWrite_out        <= RegWrite;
            MemWrite_out        <= MemWrite;
            MemRead_out         <= MemRead;
            branch_taken_out    <= branch_taken;
            branch_target_out   <= branch_target;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: directed pipeline scenarios followed by random traffic,
// each cycle's expected EX/MEM contents predicted by a reference model and checked by a monitor.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, stall, Flush;
    logic [63:0] program_counter_addr, read_data1, read_data2, immediate_value;
    logic [3:0]  function_code;
    logic [4:0]  destination_reg, source_reg1, source_reg2;
    logic        MemtoReg, RegWrite, Branch, MemWrite, MemRead, ALUSrc;
    logic [1:0]  ALU_op;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic [63:0] alu_result_out, write_data_out, branch_target_out;
    logic [4:0]  destination_reg_out;
    logic        MemtoReg_out, RegWrite_out, MemWrite_out, MemRead_out, branch_taken_out;

    ex_mem_stage #(.XLEN(64), .REG_ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .stall(stall), .Flush(Flush),
        .program_counter_addr(program_counter_addr),
        .read_data1(read_data1), .read_data2(read_data2),
        .immediate_value(immediate_value), .function_code(function_code),
        .destination_reg(destination_reg), .source_reg1(source_reg1), .source_reg2(source_reg2),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .Branch(Branch),
        .MemWrite(MemWrite), .MemRead(MemRead), .ALUSrc(ALUSrc), .ALU_op(ALU_op),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .alu_result_out(alu_result_out), .write_data_out(write_data_out),
        .destination_reg_out(destination_reg_out),
        .MemtoReg_out(MemtoReg_out), .RegWrite_out(RegWrite_out),
        .MemWrite_out(MemWrite_out), .MemRead_out(MemRead_out),
        .branch_taken_out(branch_taken_out), .branch_target_out(branch_target_out)
    );

    typedef struct packed {
        logic        rst, stl, flush;
        logic [63:0] pc, rd1, rd2, imm;
        logic [3:0]  fc;
        logic [4:0]  rd, rs1, rs2;
        logic        m2r, rw, br, mw, mr, alusrc;
        logic [1:0]  aluop;
        logic        wbw;
        logic [4:0]  wbrd;
        logic [63:0] wbdata;
    } stim_t;

    typedef struct packed {
        logic [63:0] alu, wd;
        logic [4:0]  rd;
        logic        m2r, rw, mw, mr, bt;
        logic [63:0] tgt;
    } out_t;

    out_t        model = '0;
    out_t        exp_q[$];
    string       tag_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [3:0]  rcodes [10] = '{4'h0, 4'h8, 4'h7, 4'h6, 4'h4, 4'h1, 4'h5, 4'hD, 4'h2, 4'h3};

    // Reference ALU written from the operation table in plain arithmetic.
    function automatic logic [63:0] ref_alu(input stim_t s, input logic [63:0] a, input logic [63:0] b);
        logic [3:0] code;
        logic [5:0] sh;
        sh = b[5:0];
        if (s.aluop == 2'b00) return a + b;
        if (s.aluop == 2'b01) return a - b;
        code = s.fc;
        if (s.aluop == 2'b11 && s.fc[2:0] != 3'b101) code[3] = 1'b0;
        case (code)
            4'h8:    return a - b;
            4'h7:    return a & b;
            4'h6:    return a | b;
            4'h4:    return a ^ b;
            4'h1:    return a << sh;
            4'h5:    return a >> sh;
            4'hD:    return $signed(a) >>> sh;
            4'h2:    return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'h3:    return (a < b) ? 64'd1 : 64'd0;
            default: return a + b;
        endcase
    endfunction

    function automatic logic ref_taken(input stim_t s, input logic [63:0] a, input logic [63:0] b);
        if (!s.br) return 1'b0;
        case (s.fc[2:0])
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] operand(input logic [4:0] rs, input logic [63:0] rf, input stim_t s, input out_t m);
        if (m.rw && m.rd != 0 && m.rd == rs) return m.alu;
        if (s.wbw && s.wbrd != 0 && s.wbrd == rs) return s.wbdata;
        return rf;
    endfunction

    function automatic stim_t rtype(input logic [3:0] fc, input logic [4:0] rd, input logic [4:0] rs1,
                                    input logic [4:0] rs2, input logic [63:0] d1, input logic [63:0] d2);
        stim_t s;
        s = '0;
        s.aluop = 2'b10; s.rw = 1'b1; s.fc = fc;
        s.rd = rd; s.rs1 = rs1; s.rs2 = rs2; s.rd1 = d1; s.rd2 = d2;
        return s;
    endfunction

    function automatic stim_t branch_op(input logic [2:0] f3, input logic [63:0] d1, input logic [63:0] d2);
        stim_t s;
        s = '0;
        s.br = 1'b1; s.aluop = 2'b01; s.fc = {1'b0, f3};
        s.rs1 = 5'd10; s.rs2 = 5'd11; s.rd1 = d1; s.rd2 = d2;
        s.pc = 64'h100; s.imm = 64'h20;
        return s;
    endfunction

    task automatic step(input stim_t s, input string tag);
        out_t        nx;
        logic [63:0] a, b;
        @(negedge clk);
        reset = s.rst; stall = s.stl; Flush = s.flush;
        program_counter_addr = s.pc; read_data1 = s.rd1; read_data2 = s.rd2;
        immediate_value = s.imm; function_code = s.fc;
        destination_reg = s.rd; source_reg1 = s.rs1; source_reg2 = s.rs2;
        MemtoReg = s.m2r; RegWrite = s.rw; Branch = s.br; MemWrite = s.mw;
        MemRead = s.mr; ALUSrc = s.alusrc; ALU_op = s.aluop;
        wb_reg_write = s.wbw; wb_rd = s.wbrd; wb_data = s.wbdata;
        a = operand(s.rs1, s.rd1, s, model);
        b = operand(s.rs2, s.rd2, s, model);
        nx = '0;
        if (s.rst || s.flush || model.bt) begin
            nx = '0;
        end else if (s.stl) begin
            nx = model;
            nx.bt = 1'b0;
        end else begin
            nx.alu = ref_alu(s, a, s.alusrc ? s.imm : b);
            nx.wd  = b;
            nx.rd  = s.rd;
            nx.m2r = s.m2r; nx.rw = s.rw; nx.mw = s.mw; nx.mr = s.mr;
            nx.bt  = ref_taken(s, a, b);
            nx.tgt = s.pc + s.imm;
        end
        model = nx;
        exp_q.push_back(nx);
        tag_q.push_back(tag);
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s = '0;
        s.rst   = ($urandom_range(0, 49) == 0);
        s.stl   = ($urandom_range(0, 6) == 0);
        s.flush = ($urandom_range(0, 11) == 0);
        s.pc    = {$urandom, $urandom};
        s.rd1   = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 70)) : {$urandom, $urandom};
        s.rd2   = ($urandom_range(0, 2) == 0) ? s.rd1 : {$urandom, $urandom};
        s.imm   = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 127)) : {$urandom, $urandom};
        s.aluop = 2'($urandom_range(0, 3));
        s.fc    = (s.aluop == 2'b10) ? rcodes[$urandom_range(0, 9)] : 4'($urandom_range(0, 15));
        s.rd    = 5'($urandom_range(0, 3));
        s.rs1   = 5'($urandom_range(0, 3));
        s.rs2   = 5'($urandom_range(0, 3));
        s.m2r   = 1'($urandom); s.rw = 1'($urandom); s.mw = 1'($urandom);
        s.mr    = 1'($urandom); s.alusrc = 1'($urandom);
        s.br    = ($urandom_range(0, 3) == 0);
        s.wbw   = 1'($urandom);
        s.wbrd  = 5'($urandom_range(0, 3));
        s.wbdata = {$urandom, $urandom};
        return s;
    endfunction

    initial begin : monitor
        out_t  e, g;
        string t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                g = {alu_result_out, write_data_out, destination_reg_out, MemtoReg_out,
                     RegWrite_out, MemWrite_out, MemRead_out, branch_taken_out, branch_target_out};
                tests++;
                if (g !== e) begin
                    fails++;
                    $display("FAIL %s: got alu=%h wd=%h rd=%0d m2r/rw/mw/mr=%b%b%b%b bt=%b tgt=%h; expected alu=%h wd=%h rd=%0d m2r/rw/mw/mr=%b%b%b%b bt=%b tgt=%h",
                             t, g.alu, g.wd, g.rd, g.m2r, g.rw, g.mw, g.mr, g.bt, g.tgt,
                             e.alu, e.wd, e.rd, e.m2r, e.rw, e.mw, e.mr, e.bt, e.tgt);
                end
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        reset = 1'b1; stall = 1'b0; Flush = 1'b0;
        program_counter_addr = '0; read_data1 = '0; read_data2 = '0; immediate_value = '0;
        function_code = '0; destination_reg = '0; source_reg1 = '0; source_reg2 = '0;
        MemtoReg = 1'b0; RegWrite = 1'b0; Branch = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
        ALUSrc = 1'b0; ALU_op = '0; wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;

        s = '0; s.rst = 1'b1;
        step(s, "reset");
        step(s, "reset_hold");

        step(rtype(4'h0, 5'd5, 5'd1, 5'd2, 64'd7, 64'd9), "add_x5");
        step(rtype(4'h8, 5'd6, 5'd5, 5'd1, 64'd0, 64'd4), "sub_fwd_mem");
        step(rtype(4'h0, 5'd5, 5'd1, 5'd2, 64'd7, 64'd9), "add_x5_again");
        s = rtype(4'h0, 5'd7, 5'd5, 5'd0, 64'd0, 64'd0);
        s.wbw = 1'b1; s.wbrd = 5'd5; s.wbdata = 64'd99;
        step(s, "mem_over_wb");
        s = rtype(4'h0, 5'd0, 5'd0, 5'd0, 64'd3, 64'd0);
        s.wbw = 1'b1; s.wbrd = 5'd0; s.wbdata = 64'd55;
        step(s, "x0_wb_no_fwd");
        s.rd1 = 64'd8;
        step(s, "x0_mem_no_fwd");

        step(branch_op(3'd0, 64'h10, 64'h10), "beq_taken");
        step(rtype(4'h0, 5'd3, 5'd1, 5'd2, 64'd1, 64'd2), "self_squash");
        step(rtype(4'h0, 5'd3, 5'd1, 5'd2, 64'd1, 64'd2), "after_squash");
        step(branch_op(3'd1, 64'h10, 64'h10), "bne_equal");
        step(rtype(4'h0, 5'd4, 5'd1, 5'd2, 64'd5, 64'd5), "after_bne");

        step(rtype(4'hD, 5'd8, 5'd1, 5'd2, 64'h8000_0000_0000_0000, 64'd63), "sra63");
        step(rtype(4'h3, 5'd8, 5'd1, 5'd2, '1, 64'd1), "sltu_neg1");
        step(rtype(4'h2, 5'd8, 5'd1, 5'd2, '1, 64'd1), "slt_neg1");
        s = rtype(4'h8, 5'd8, 5'd1, 5'd2, 64'd100, 64'd0);
        s.aluop = 2'b11; s.alusrc = 1'b1; s.imm = 64'd5;
        step(s, "addi_bit3");
        step(rtype(4'h0, 5'd8, 5'd1, 5'd2, '1, 64'd1), "add_wrap");

        s = '0;
        s.mw = 1'b1; s.alusrc = 1'b1; s.rs1 = 5'd12; s.rs2 = 5'd13;
        s.rd1 = 64'h30; s.imm = 64'h10; s.rd2 = 64'hABCD;
        step(s, "store_load");
        s = rtype(4'h0, 5'd9, 5'd1, 5'd2, 64'd5, 64'd6);
        s.stl = 1'b1;
        for (int i = 0; i < 3; i++) step(s, "stall_hold");
        s.stl = 1'b0;
        step(s, "after_stall");

        step(branch_op(3'd0, 64'h10, 64'h10), "beq_before_stall");
        s.stl = 1'b1;
        step(s, "stall_after_branch");
        s.stl = 1'b0;
        step(s, "resume_after_branch");

        s = rtype(4'h0, 5'd9, 5'd1, 5'd2, 64'd1, 64'd1);
        s.flush = 1'b1; s.stl = 1'b1;
        step(s, "flush_and_stall");

        step(rtype(4'h7, 5'd9, 5'd1, 5'd2, 64'hF0, 64'h3C), "pre_reset_load");
        s = rtype(4'h6, 5'd9, 5'd1, 5'd2, 64'hF0, 64'h3C);
        s.stl = 1'b1; s.rst = 1'b1;
        step(s, "reset_during_stall");
        s.stl = 1'b0; s.rst = 1'b0;
        step(s, "post_reset_load");

        for (int i = 0; i < 400; i++) step(rand_stim(), "random");

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            fails++;
            $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
